// File: rtl/req_arbiter_8.sv
// Eight-requester arbiter for one shared resource: fixed (bit 7 highest) or
// round-robin selection, grant held until release or MAX_HOLD expiry.
module req_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rr_mode,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state, state_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic [2:0] last, last_nx;
  logic [2:0] win;
  logic [7:0] grant_nx;
  logic [2:0] idx_nx;
  logic       valid_nx;
  logic       tmo_nx;

  // Highest set index wins; later loop iterations override earlier ones.
  function automatic logic [2:0] pick_fixed(input logic [7:0] r);
    logic [2:0] w;
    w = 3'd0;
    for (int i = 0; i < 8; i++)
      if (r[i]) w = 3'(i);
    return w;
  endfunction

  // Walk from last (lowest priority) up to last-1 (highest) so the
  // highest-priority set bit is written last.
  function automatic logic [2:0] pick_rr(input logic [7:0] r, input logic [2:0] l);
    logic [2:0] w;
    logic [2:0] c;
    w = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      c = l - 3'(i);
      if (r[c]) w = c;
    end
    return w;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    last_nx  = last;
    grant_nx = grant;
    idx_nx   = grant_idx;
    valid_nx = grant_valid;
    tmo_nx   = 1'b0;
    win      = rr_mode ? pick_rr(req, last) : pick_fixed(req);
    case (state)
      IDLE: begin
        if (req != 8'd0) begin
          grant_nx = 8'd1 << win;
          idx_nx   = win;
          valid_nx = 1'b1;
          hold_nx  = 8'd1;
          last_nx  = win;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (!req[grant_idx] || (MAX_HOLD != 0 && hold_cnt == HOLD_LIM)) begin
          grant_nx = 8'd0;
          idx_nx   = 3'd0;
          valid_nx = 1'b0;
          tmo_nx   = req[grant_idx];
          state_nx = GAP;
        end else begin
          hold_nx = sat_inc(hold_cnt);
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= 8'd0;
      last        <= 3'd0;
      grant       <= 8'd0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      last        <= last_nx;
      grant       <= grant_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      timeout     <= tmo_nx;
    end
  end

endmodule

// File: tb/tb_req_arbiter_8.sv
// Bench for req_arbiter_8: three instances (MAX_HOLD 1, 4, unlimited) share
// stimulus and are compared every cycle against a behavioural model.
module tb_req_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rr_mode;
  logic [7:0] req;
  logic [7:0] g  [3];
  logic [2:0] gi [3];
  logic       gv [3];
  logic       to [3];

  int tests = 0;
  int fails = 0;

  int m_own  [3];
  int m_held [3];
  int m_dead [3];
  int m_last [3];
  bit m_tmo  [3];
  bit armed = 1'b0;

  always #5 clk = ~clk;

  req_arbiter_8 #(.MAX_HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
    .grant(g[0]), .grant_idx(gi[0]), .grant_valid(gv[0]), .timeout(to[0]));
  req_arbiter_8 #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
    .grant(g[1]), .grant_idx(gi[1]), .grant_valid(gv[1]), .timeout(to[1]));
  req_arbiter_8 #(.MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
    .grant(g[2]), .grant_idx(gi[2]), .grant_valid(gv[2]), .timeout(to[2]));

  function automatic int lim(input int h);
    return (h == 0) ? 1 : (h == 1) ? 4 : 0;
  endfunction

  function automatic int pick(input bit [7:0] r, input bit rr, input int lst);
    if (!rr) begin
      for (int i = 7; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int s = 1; s <= 8; s++) if (r[(lst - s + 8) % 8]) return (lst - s + 8) % 8;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int h, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, h, act, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_step();
    for (int h = 0; h < 3; h++) begin
      if (rst) begin
        m_own[h] = -1; m_held[h] = 0; m_dead[h] = 0; m_last[h] = 0; m_tmo[h] = 0;
        armed = 1'b1;
      end else if (m_own[h] >= 0) begin
        m_tmo[h] = 0;
        if (!req[m_own[h]]) begin
          m_own[h] = -1; m_dead[h] = 1;
        end else if (lim(h) != 0 && m_held[h] == lim(h)) begin
          m_own[h] = -1; m_dead[h] = 1; m_tmo[h] = 1;
        end else if (m_held[h] < 255) begin
          m_held[h]++;
        end
      end else begin
        m_tmo[h] = 0;
        if (m_dead[h] > 0) m_dead[h]--;
        else if (req != 8'd0) begin
          m_own[h] = pick(req, rr_mode, m_last[h]);
          m_held[h] = 1;
          m_last[h] = m_own[h];
        end
      end
    end
  endtask

  task automatic cmp_all();
    if (armed) begin
      for (int h = 0; h < 3; h++) begin
        chk("grant",       h, int'(g[h]),  (m_own[h] >= 0) ? (1 << m_own[h]) : 0);
        chk("grant_idx",   h, int'(gi[h]), (m_own[h] >= 0) ? m_own[h] : 0);
        chk("grant_valid", h, int'(gv[h]), (m_own[h] >= 0) ? 1 : 0);
        chk("timeout",     h, int'(to[h]), int'(m_tmo[h]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int h, output int idx, output int cyc);
    cyc = 0;
    while (!gv[h] && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!gv[h]) chk("grant_wait", h, 0, 1);
    idx = int'(gi[h]);
  endtask

  task automatic wait_release(input int h);
    int n;
    n = 0;
    while (gv[h] && n < 40) begin
      tick();
      n++;
    end
    if (gv[h]) chk("release_wait", h, 1, 0);
  endtask

  initial begin
    int idx, c, n;
    int seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    rst = 1'b1; req = 8'd0; rr_mode = 1'b0;

    // Reset with no requests: all outputs low and stay low.
    do_reset();
    tick();
    for (int h = 0; h < 3; h++) begin
      chk("rst_grant", h, int'(g[h]), 0);
      chk("rst_idx",   h, int'(gi[h]), 0);
      chk("rst_valid", h, int'(gv[h]), 0);
      chk("rst_tmo",   h, int'(to[h]), 0);
    end

    // Fixed priority, release, two dead cycles, next winner.
    req = 8'b0010_0110;
    wait_grant(2, idx, c);
    chk("fx_idx", 2, idx, 5);
    chk("fx_lat", 2, c, 1);
    chk("fx_onehot", 2, int'(g[2]), 8'h20);
    req = 8'b0000_0110;
    tick();
    chk("fx_drop", 2, int'(gv[2]), 0);
    wait_grant(2, idx, c);
    chk("fx_idx2", 2, idx, 2);
    chk("fx_dead", 2, c, 2);

    // Round-robin rotation with MAX_HOLD=1.
    req = 8'd0;
    do_reset();
    rr_mode = 1'b1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      wait_grant(0, idx, c);
      chk("rr_idx", k, idx, seq[k]);
      if (k > 0) chk("rr_dead", k, c, 2);
      tick();
      chk("rr_tmo", k, int'(to[0]), 1);
      chk("rr_len", k, int'(gv[0]), 0);
    end

    // Hold limit of 4 cycles with a single persistent requester.
    req = 8'd0; rr_mode = 1'b0;
    do_reset();
    req = 8'h01;
    wait_grant(1, idx, c);
    n = 0;
    while (gv[1] && n < 20) begin
      n++;
      tick();
    end
    chk("hold_len", 1, n, 4);
    chk("hold_tmo", 1, int'(to[1]), 1);
    wait_grant(1, idx, c);
    chk("hold_regrant", 1, idx, 0);
    chk("hold_dead", 1, c, 2);

    // Reset in the middle of a grant.
    req = 8'd0;
    do_reset();
    req = 8'h08;
    wait_grant(2, idx, c);
    chk("mr_idx", 2, idx, 3);
    rst = 1'b1; req = 8'h18;
    tick();
    chk("mr_grant", 2, int'(g[2]), 0);
    chk("mr_valid", 2, int'(gv[2]), 0);
    chk("mr_idx0",  2, int'(gi[2]), 0);
    rst = 1'b0;
    tick();
    chk("mr_next", 2, int'(gi[2]), 4);
    chk("mr_nextv", 2, int'(gv[2]), 1);

    // Mode switched to round-robin while owner 6 is busy.
    req = 8'd0; rr_mode = 1'b0;
    do_reset();
    req = 8'h40;
    wait_grant(1, idx, c);
    chk("mc_own", 1, idx, 6);
    req = 8'hC0; rr_mode = 1'b1;
    wait_release(1);
    chk("mc_tmo", 1, int'(to[1]), 1);
    wait_grant(1, idx, c);
    chk("mc_next", 1, idx, 7);
    wait_release(1);
    wait_grant(1, idx, c);
    chk("mc_rot", 1, idx, 6);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) req = 8'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) rr_mode = 1'($urandom);
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
